pch_unit: RTL

Program-counter high-byte stage of the 65C02 core, directly downstream of the PC low-byte register. Holds PC[15:8] and drives it onto the address-high bus and the data bus. Consumes the low byte's `carry_to_pch` level through a four-phase handshake and returns `carry_done`. Also loads the high byte from decode, vector and address sources, and applies the one-cycle page-cross correction after taken relative branches.

---
 rtl/pc_pkg.sv | 38 +++
 rtl/pch_carry_fsm.sv | 120 ++++++++++++
 rtl/pch_unit.sv | 79 +++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Types and constants shared by the program-counter byte stages.
// Holds the high-byte FSM state type, the vector page and the load-select encoding.
package pc_pkg;

  typedef enum logic [1:0] {
    PCH_IDLE = 2'd0,
    PCH_ACK  = 2'd1,
    PCH_FIX  = 2'd2
  } pch_state_t;

  localparam logic [7:0] PC_VECTOR_PAGE = 8'hFF;

  typedef enum logic [1:0] {
    PC_LD_NONE   = 2'd0,
    PC_LD_DB     = 2'd1,
    PC_LD_VECTOR = 2'd2,
    PC_LD_ADB    = 2'd3
  } pc_load_sel_t;

  // Priority: decode > any vector push > address bus.
  function automatic pc_load_sel_t pc_load_select(
    input logic decode,
    input logic resb,
    input logic irqb,
    input logic nmib,
    input logic adb
  );
    if (decode)
      return PC_LD_DB;
    else if (resb || irqb || nmib)
      return PC_LD_VECTOR;
    else if (adb)
      return PC_LD_ADB;
    else
      return PC_LD_NONE;
  endfunction

endpackage

// File: rtl/pch_carry_fsm.sv
// Carry handshake and page-cross fix sequencer for the PC high byte.
// Branch correction (pending bit, FIX state) is built only with PCH_BRANCH_FIX_EN.
module pch_carry_fsm
  import pc_pkg::*;
(
  input  logic         clk,
  input  logic         srst,
  input  logic         load_decode,
  input  logic         load_resb,
  input  logic         load_irqb,
  input  logic         load_nmib,
  input  logic         load_adb,
  input  logic         carry_req,
  input  logic         fix_req,
  input  logic         fix_dir,
  output pc_load_sel_t load_sel,
  output logic         inc,
  output logic         dec,
  output logic         carry_done,
  output logic         branch_stall,
  output logic         busy
);

  pch_state_t state_reg;
  pch_state_t state_next;
  logic       any_load;

  always_comb begin
    load_sel = pc_load_select(load_decode, load_resb, load_irqb, load_nmib, load_adb);
  end

  assign any_load = (load_sel != PC_LD_NONE);

`ifdef PCH_BRANCH_FIX_EN
  logic pending_reg;
  logic pending_next;
  logic dir_reg;
  logic dir_next;

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg | fix_req;
    dir_next     = fix_req ? fix_dir : dir_reg;
    inc          = 1'b0;
    dec          = 1'b0;
    case (state_reg)
      PCH_IDLE: begin
        // A carry always goes first; a pending fix waits for the next IDLE.
        if (carry_req) begin
          state_next = PCH_ACK;
          inc        = !any_load;
        end else if (pending_reg || fix_req) begin
          state_next = PCH_FIX;
        end
      end
      PCH_ACK: begin
        if (!carry_req)
          state_next = PCH_IDLE;
      end
      PCH_FIX: begin
        inc          = !any_load && !dir_reg;
        dec          = !any_load && dir_reg;
        pending_next = fix_req;
        state_next   = PCH_IDLE;
      end
      default: state_next = PCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg   <= PCH_IDLE;
      pending_reg <= 1'b0;
      dir_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      dir_reg     <= dir_next;
    end
  end

  assign branch_stall = (state_reg == PCH_FIX);
`else
  // Branch inputs have no effect in this build.
  logic fix_unused;
  assign fix_unused = fix_req ^ fix_dir;

  always_comb begin
    state_next = state_reg;
    inc        = 1'b0;
    case (state_reg)
      PCH_IDLE: begin
        if (carry_req) begin
          state_next = PCH_ACK;
          inc        = !any_load;
        end
      end
      PCH_ACK: begin
        if (!carry_req)
          state_next = PCH_IDLE;
      end
      default: state_next = PCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst)
      state_reg <= PCH_IDLE;
    else
      state_reg <= state_next;
  end

  assign dec          = 1'b0;
  assign branch_stall = 1'b0;
`endif

  assign carry_done = (state_reg == PCH_ACK);
  assign busy       = (state_reg != PCH_IDLE);

endmodule

// File: rtl/pch_unit.sv
// PC high-byte register with loads, low-byte carry handshake and page-cross fix.
// Optional branch correction is enabled with PCH_BRANCH_FIX_EN.
module pch_unit
  import pc_pkg::*;
#(
  parameter logic [7:0] RESET_PCH   = 8'hFF,
  parameter logic [7:0] VECTOR_PAGE = PC_VECTOR_PAGE
) (
  input  logic       fclk,
  input  logic       reset,
  input  logic       instruction_decode_in,
  input  logic       push_resb,
  input  logic       push_irqb,
  input  logic       push_nmib,
  input  logic       adb_to_pc,
  input  logic [7:0] db_in,
  input  logic [7:0] address_high_in,
  input  logic       carry_to_pch,
  output logic       carry_done,
  input  logic       branch_fix,
  input  logic       branch_dir,
  output logic       branch_stall,
  output logic       busy,
  output logic [7:0] address_high_out,
  output logic [7:0] db_out
);

  pc_load_sel_t load_sel;
  logic         inc;
  logic         dec;
  logic [7:0]   pch_reg;
  logic [7:0]   pch_next;

  pch_carry_fsm u_fsm (
    .clk          (fclk),
    .srst         (reset),
    .load_decode  (instruction_decode_in),
    .load_resb    (push_resb),
    .load_irqb    (push_irqb),
    .load_nmib    (push_nmib),
    .load_adb     (adb_to_pc),
    .carry_req    (carry_to_pch),
    .fix_req      (branch_fix),
    .fix_dir      (branch_dir),
    .load_sel     (load_sel),
    .inc          (inc),
    .dec          (dec),
    .carry_done   (carry_done),
    .branch_stall (branch_stall),
    .busy         (busy)
  );

  // Loads override any +/-1; arithmetic wraps within the byte.
  always_comb begin
    pch_next = pch_reg;
    case (load_sel)
      PC_LD_DB:     pch_next = db_in;
      PC_LD_VECTOR: pch_next = VECTOR_PAGE;
      PC_LD_ADB:    pch_next = address_high_in;
      default: begin
        if (inc)
          pch_next = pch_reg + 8'd1;
        else if (dec)
          pch_next = pch_reg - 8'd1;
      end
    endcase
  end

  always_ff @(posedge fclk) begin
    if (reset)
      pch_reg <= RESET_PCH;
    else
      pch_reg <= pch_next;
  end

  assign address_high_out = pch_reg;
  assign db_out           = pch_reg;

endmodule
